// File: rtl/simple_bus_pkg.sv
// Shared definitions for the simple command bus: opcodes, FSM states and
// per-opcode execution latency, used by the responder and by bus drivers.
package simple_bus_pkg;

  localparam int CMD_W     = 4;
  localparam int ARITH_LAT = 2;
  localparam int SHIFT_LAT = 3;
  localparam int LAT_W     = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP  = 4'd0,
    CMD_LOAD = 4'd1,
    CMD_ADD  = 4'd2,
    CMD_SUB  = 4'd3,
    CMD_SHL  = 4'd4,
    CMD_CLR  = 4'd5
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Extra EXEC cycles spent before the result is written; illegal opcodes take none.
  function automatic logic [LAT_W-1:0] cmd_latency(input logic [CMD_W-1:0] op);
    logic [LAT_W-1:0] lat;
    lat = '0;
    if (op == CMD_ADD || op == CMD_SUB) lat = LAT_W'(ARITH_LAT);
    else if (op == CMD_SHL)             lat = LAT_W'(SHIFT_LAT);
    return lat;
  endfunction

endpackage

// File: rtl/simple_bus_alu.sv
// Combinational datapath of the responder: applies one opcode to the
// accumulator and flags opcodes outside the defined set.
module simple_bus_alu
  import simple_bus_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [CMD_W-1:0] op,
  input  logic [W-1:0]     acc,
  input  logic [W-1:0]     operand,
  output logic [W-1:0]     result,
  output logic             illegal
);

  // Illegal opcodes pass the accumulator through so the write-back stays uniform.
  always_comb begin
    result  = acc;
    illegal = 1'b0;
    if (op == CMD_NOP)       result = acc;
    else if (op == CMD_LOAD) result = operand;
    else if (op == CMD_ADD)  result = acc + operand;
    else if (op == CMD_SUB)  result = acc - operand;
    else if (op == CMD_SHL)  result = acc << operand[3:0];
    else if (op == CMD_CLR)  result = '0;
    else                     illegal = 1'b1;
  end

endmodule

// File: rtl/simple_bus_responder.sv
// Target end of the simple command bus: accepts one command at a time,
// runs it against a 16-bit accumulator and pulses done when it completes.
module simple_bus_responder
  import simple_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [ADDR_W-1:0] saddr,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] acc,
  output logic [CNT_W-1:0]  cmd_count,
  output logic [CNT_W-1:0]  err_count
);

  state_e             state, state_nxt;
  logic [LAT_W-1:0]   cnt, cnt_nxt;
  logic [CMD_W-1:0]   cmd_q;
  logic [ADDR_W-1:0]  saddr_q;
  logic               latch;
  logic               finish;
  logic [ADDR_W-1:0]  alu_result;
  logic               alu_illegal;

  simple_bus_alu #(.W(ADDR_W)) u_alu (
    .op      (cmd_q),
    .acc     (acc),
    .operand (saddr_q),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = EXEC;
          latch     = 1'b1;
          cnt_nxt   = cmd_latency(cmd);
        end
      end
      EXEC: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - LAT_W'(1);
        end else begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done/err are registered on the same edge that enters DONE, so they span exactly that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_q     <= '0;
      saddr_q   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      cmd_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= finish;
      err   <= finish & alu_illegal;
      if (latch) begin
        cmd_q   <= cmd;
        saddr_q <= saddr;
      end
      if (finish) begin
        acc <= alu_result;
        if (alu_illegal) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
        end else begin
          if (cmd_count != '1) cmd_count <= cmd_count + CNT_W'(1);
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_simple_bus_responder.sv
// Randomized scoreboard bench for simple_bus_responder against an
// arithmetic reference model of the command set and its timing.
module tb_simple_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  cmd;
  logic [15:0] saddr;
  logic        done;
  logic        err;
  logic        busy;
  logic [15:0] acc;
  logic [15:0] cmd_count;
  logic [15:0] err_count;

  simple_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cmd       (cmd),
    .saddr     (saddr),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .acc       (acc),
    .cmd_count (cmd_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int exp_acc;
    int exp_err;
    int exp_cmd;
    int exp_errc;
    int exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_acc = 0;
  int   m_cmd = 0;
  int   m_errc = 0;
  int   lat_tab[16] = '{0, 0, 2, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Reference model: the sampling edge is the next posedge, done shows lat+1 edges later.
  task automatic pushExpected(input int op, input int a);
    exp_t e;
    int   lat;
    lat = 0;
    case (op)
      0: ;
      1: m_acc = a;
      2: m_acc = (m_acc + a) % 65536;
      3: m_acc = (m_acc - a + 65536) % 65536;
      4: m_acc = (m_acc * (2 ** (a % 16))) % 65536;
      5: m_acc = 0;
      default: ;
    endcase
    if (op <= 5) begin
      lat = lat_tab[op];
      if (m_cmd < 65535) m_cmd++;
    end else begin
      if (m_errc < 65535) m_errc++;
    end
    e.op       = op;
    e.exp_acc  = m_acc;
    e.exp_err  = (op > 5) ? 1 : 0;
    e.exp_cmd  = m_cmd;
    e.exp_errc = m_errc;
    e.exp_cyc  = cyc + 2 + lat;
    sb.push_back(e);
  endtask

  // While the responder is busy, en/cmd/saddr are scrambled (or en held high) to prove they are ignored.
  task automatic applyStimulus(input int op, input int a, input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    while (busy) begin
      en    = hold ? 1'b1 : 1'($urandom);
      cmd   = hold ? 4'(op) : 4'($urandom);
      saddr = 16'($urandom);
      waited++;
      if (waited > 40) begin
        checkOutput("idle_timeout", waited, 0);
        return;
      end
      @(negedge clk);
    end
    en    = 1'b1;
    cmd   = 4'(op);
    saddr = 16'(a);
    pushExpected(op, a);
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en    = busy ? 1'($urandom) : 1'b0;
      cmd   = 4'($urandom);
      saddr = 16'($urandom);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_err"}, int'(err), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_acc"}, int'(acc), 0);
    checkOutput({tag, "_cmd_count"}, int'(cmd_count), 0);
    checkOutput({tag, "_err_count"}, int'(err_count), 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle", cyc, e.exp_cyc);
          checkOutput("acc", int'(acc), e.exp_acc);
          checkOutput("err", int'(err), e.exp_err);
          checkOutput("busy_in_done", int'(busy), 1);
          checkOutput("cmd_count", int'(cmd_count), e.exp_cmd);
          checkOutput("err_count", int'(err_count), e.exp_errc);
        end
      end else begin
        if (err) checkOutput("err_without_done", int'(err), 0);
        if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
          checkOutput("done_missing", cyc, sb[0].exp_cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int op;
    rst   = 1'b1;
    en    = 1'b0;
    cmd   = 4'h0;
    saddr = 16'h0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1, 16'h1234, 1'b0);
    applyStimulus(1, 16'h0002, 1'b0);
    applyStimulus(2, 16'hFFFF, 1'b0);
    applyStimulus(15, 16'h5555, 1'b0);
    applyStimulus(1, 16'h0001, 1'b0);
    applyStimulus(4, 16'h000F, 1'b0);
    applyStimulus(5, 16'h0000, 1'b1);
    applyStimulus(5, 16'h0000, 1'b1);
    applyStimulus(1, 16'h0000, 1'b0);
    applyStimulus(3, 16'h0001, 1'b0);
    applyIdle(6);
    checkOutput("drained_directed", sb.size(), 0);

    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 5) : $urandom_range(6, 15);
      applyStimulus(op, int'($urandom_range(0, 65535)), 1'($urandom));
      if ($urandom_range(0, 7) == 0) applyIdle($urandom_range(1, 4));
    end
    applyIdle(8);

    applyStimulus(2, 16'h0010, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    en = 1'b0;
    #1;
    checkResetOutputs("midexec_reset");
    sb.delete();
    m_acc  = 0;
    m_cmd  = 0;
    m_errc = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    applyIdle(4);
    applyStimulus(1, 16'h00AA, 1'b0);
    applyIdle(8);

    checkOutput("pending_at_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
